wb_arbiter: RTL
===============

# wb_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (the mem/wb stage outputs) and a long-latency result source (divider, uncached load unit) that completes out of step with the pipeline. Long-latency results are held in a one-entry buffer. The pipeline always wins contention unless the buffer has starved, in which case the block requests a pipeline stall to drain it. Sits between the mem/wb pipeline register and the register file; its stall request feeds the pipeline control unit.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- STARVE_MAX, 4, consecutive lost arbitration cycles before stall_req asserts (1..15)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- wb_wreg  input  1  pipeline write enable
- wb_wd  input  ADDR_W  pipeline destination register
- wb_wdata  input  DATA_W  pipeline write data
- stall_wb  input  1  the mem/wb stage is held this cycle; its write will be re-presented next cycle
- lu_valid  input  1  long-latency result valid
- lu_wd  input  ADDR_W  long-latency destination register
- lu_wdata  input  DATA_W  long-latency result data
- lu_ready  output  1  buffer can accept (equals !buf_v)
- rf_we  output  1  register-file write enable (registered)
- rf_waddr  output  ADDR_W  register-file write address (registered)
- rf_wdata  output  DATA_W  register-file write data (registered)
- stall_req  output  1  request to stall the pipeline so the buffer can drain

## Operation
- State: buf_v, buf_wd, buf_wdata, starve_cnt (4 bits, saturates at STARVE_MAX).
- Accept: lu_valid && lu_ready loads buffer and sets buf_v; starve_cnt <= 0. An entry with lu_wd == 0 is accepted and discarded (buf_v stays 0).
- pipe_req = wb_wreg && wb_wd != 0. Writes to register 0 are never issued.
- Grant, evaluated each cycle in this priority:
  1. buf_v && stall_req && stall_wb: buffer wins.
  2. pipe_req: pipeline wins.
  3. buf_v: buffer wins.
  4. Otherwise no write; rf_we <= 0.
- Buffer granted: rf_* <= buffer; buf_v <= 0; starve_cnt <= 0.
- Buffer valid and not granted: starve_cnt <= min(starve_cnt+1, STARVE_MAX).
- WAW rule: pipeline granted with wb_wd == buf_wd while buf_v: the buffer entry is discarded (buf_v <= 0, starve_cnt <= 0). The younger pipeline write prevails.
- stall_req = buf_v && starve_cnt == STARVE_MAX. It is combinational from registered state.
- Because lu_ready = !buf_v, accept and drain never occur in the same cycle. A new entry is accepted no earlier than the cycle after a drain.

## Timing
- Reset (rst low, asynchronous): buf_v=0, starve_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0. Therefore lu_ready=1 and stall_req=0. A pending buffered write is lost.
- Pipeline write latency: 1 cycle from wb_* sampled to rf_* valid.
- Long-latency write: minimum 2 cycles from lu_valid accepted to rf_we, when the pipeline is idle.
- stall_req rises the cycle starve_cnt reaches STARVE_MAX. It falls the cycle after the buffer is granted or discarded.
- If stall_req is high and stall_wb is low, the pipeline still wins. stall_req holds until stall_wb is seen.

## Configuration
- WB_ARB_STARVE_EN defined: starvation counter and stall_req behave as above.
- WB_ARB_STARVE_EN undefined:
  - stall_req is tied 0 and the counter is removed.
  - Grant rule 1 never fires, so the buffer drains only in cycles with no pipe_req.
  - All other behaviour is unchanged.

## Test plan
- Idle pipeline, lu_valid with lu_wd=5, lu_wdata=0x00001234 at edge N: lu_ready=0 after N; rf_we=1, rf_waddr=5, rf_wdata=0x00001234 after N+1; lu_ready=1 again.
- Pipeline writes r3 every cycle and buffer holds r7 (STARVE_MAX=4): stall_req=1 after 4 lost edges. With stall_wb=1 on the next edge: rf writes r7, then stall_req=0, and the next edge writes r3.
- WAW: buffer holds r9=0xAAAA and pipeline writes r9=0xBBBB: rf writes r9=0xBBBB, buf_v clears, and r9=0xAAAA is never written.
- Register 0: wb_wd=0 with wb_wreg=1 gives rf_we=0. lu_wd=0 is accepted, lu_ready stays 1, and no write occurs.
- Reset mid-operation: with buf_v=1 and stall_req=1, drop rst low asynchronously. All outputs go to their reset values immediately and no buffered write appears after release.
- Build without WB_ARB_STARVE_EN: continuous pipe_req for 20 cycles with buffer valid gives stall_req=0 throughout. The buffer writes on the first idle cycle.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback competes with a one-entry long-latency result buffer.
// Optional macro WB_ARB_STARVE_EN adds the starvation counter and the stall_req drain request.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_wreg,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              stall_wb,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_wd,
  input  logic [DATA_W-1:0] lu_wdata,
  output logic              lu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_req
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic              r_buf_v;
  logic [ADDR_W-1:0] r_buf_wd;
  logic [DATA_W-1:0] r_buf_wdata;

  logic w_pipe_req;
  logic w_grant_buf;
  logic w_grant_pipe;
  logic w_buf_drop;
  logic w_accept;

  assign w_pipe_req = wb_wreg && (wb_wd != {ADDR_W{1'b0}});
  assign w_accept   = lu_valid && !r_buf_v;
  assign lu_ready   = !r_buf_v;

`ifdef WB_ARB_STARVE_EN
  logic [3:0] r_starve_cnt;

  assign stall_req    = r_buf_v && (r_starve_cnt == STARVE_LIM);
  assign w_grant_buf  = r_buf_v && ((stall_req && stall_wb) || !w_pipe_req);
`else
  logic [4:0] w_unused_cfg;

  assign w_unused_cfg = {stall_wb, STARVE_LIM};
  assign stall_req    = 1'b0;
  assign w_grant_buf  = r_buf_v && !w_pipe_req;
`endif

  assign w_grant_pipe = w_pipe_req && !w_grant_buf;
  // A pipeline write to the buffered register is younger, so it supersedes the buffer entry.
  assign w_buf_drop   = w_grant_buf || (w_grant_pipe && r_buf_v && (wb_wd == r_buf_wd));

`ifdef WB_ARB_STARVE_EN
  // Count consecutive cycles the buffer loses arbitration, saturating at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= 4'd0;
    end else if (w_accept || w_buf_drop) begin
      r_starve_cnt <= 4'd0;
    end else if (r_buf_v && (r_starve_cnt != STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`endif

  // Register-file write port and result buffer state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we       <= 1'b0;
      rf_waddr    <= {ADDR_W{1'b0}};
      rf_wdata    <= {DATA_W{1'b0}};
      r_buf_v     <= 1'b0;
      r_buf_wd    <= {ADDR_W{1'b0}};
      r_buf_wdata <= {DATA_W{1'b0}};
    end else begin
      if (w_grant_buf) begin
        rf_we    <= 1'b1;
        rf_waddr <= r_buf_wd;
        rf_wdata <= r_buf_wdata;
      end else if (w_grant_pipe) begin
        rf_we    <= 1'b1;
        rf_waddr <= wb_wd;
        rf_wdata <= wb_wdata;
      end else begin
        rf_we    <= 1'b0;
      end

      // Accept and drain are mutually exclusive because accept needs an empty buffer.
      if (w_accept) begin
        r_buf_v     <= (lu_wd != {ADDR_W{1'b0}});
        r_buf_wd    <= lu_wd;
        r_buf_wdata <= lu_wdata;
      end else if (w_buf_drop) begin
        r_buf_v     <= 1'b0;
      end else begin
        r_buf_v     <= r_buf_v;
      end
    end
  end

endmodule
